// File: rtl/float_mult_pipe.sv
// float_mult_pipe: 3-stage IEEE-754-style multiplier with RNE rounding, exceptions and valid/ready flow control
module float_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);
  localparam int P = MAN_W + 1;
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0] BIAS = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic [EXP_W-1:0] EMAX = '1;
  logic stall;
  logic v1, v2;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic za, zb, ia, ib, na, nb;
  logic s1_sign, s1_nv, s1_inf, s1_zero;
  logic [EXP_W-1:0] s1_ea, s1_eb;
  logic [2*P-1:0] s1_prod;
  logic norm, g_n, r_n, st_n;
  logic [P-1:0] man_n;
  logic [EW-1:0] e_n;
  logic s2_sign, s2_nv, s2_inf, s2_zero, s2_g, s2_r, s2_s;
  logic [P-1:0] s2_man;
  logic [EW-1:0] s2_e;
  logic inc, ovf, unf;
  logic [P:0] sum;
  logic [EW-1:0] er;
  logic [MAN_W-1:0] frac;
  logic [EXP_W+MAN_W:0] res_n;
  logic [3:0] flg_n;
  assign stall = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign ea = a[EXP_W+MAN_W-1:MAN_W];
  assign eb = b[EXP_W+MAN_W-1:MAN_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];
  // subnormal inputs are flushed: any zero exponent counts as zero
  assign za = ~|ea;
  assign zb = ~|eb;
  assign ia = &ea & ~|fa;
  assign ib = &eb & ~|fb;
  assign na = &ea & |fa;
  assign nb = &eb & |fb;
  always_comb begin
    norm = s1_prod[2*P-1];
    man_n = norm ? s1_prod[2*P-1 -: P] : s1_prod[2*P-2 -: P];
    g_n = norm ? s1_prod[P-1] : s1_prod[P-2];
    r_n = norm ? s1_prod[P-2] : s1_prod[P-3];
    st_n = norm ? |s1_prod[P-3:0] : |s1_prod[P-4:0];
    e_n = {2'b00, s1_ea} + {2'b00, s1_eb} - BIAS + {{(EW-1){1'b0}}, norm};
  end
  always_comb begin
    inc = s2_g & (s2_r | s2_s | s2_man[0]);
    sum = {1'b0, s2_man} + {{P{1'b0}}, inc};
    frac = sum[P] ? sum[MAN_W:1] : sum[MAN_W-1:0];
    er = s2_e + {{(EW-1){1'b0}}, sum[P]};
    ovf = ~er[EW-1] & (er[EW-2:0] >= {1'b0, EMAX});
    unf = er[EW-1] | (er == '0);
    res_n = s2_nv ? {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}}
          : s2_inf ? {s2_sign, EMAX, {MAN_W{1'b0}}}
          : s2_zero ? {s2_sign, {(EXP_W+MAN_W){1'b0}}}
          : ovf ? {s2_sign, EMAX, {MAN_W{1'b0}}}
          : unf ? {s2_sign, {(EXP_W+MAN_W){1'b0}}}
          : {s2_sign, er[EXP_W-1:0], frac};
    flg_n = s2_nv ? 4'b1000
          : (s2_inf | s2_zero) ? 4'b0000
          : ovf ? 4'b0101
          : unf ? 4'b0011
          : {3'b000, s2_g | s2_r | s2_s};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      result <= '0;
      flags <= '0;
    end else if (~stall) begin
      v1 <= in_valid;
      v2 <= v1;
      out_valid <= v2;
      s1_sign <= a[EXP_W+MAN_W] ^ b[EXP_W+MAN_W];
      s1_nv <= na | nb | (ia & zb) | (za & ib);
      s1_inf <= ia | ib;
      s1_zero <= za | zb;
      s1_ea <= ea;
      s1_eb <= eb;
      s1_prod <= {{P{1'b0}}, 1'b1, fa} * {{P{1'b0}}, 1'b1, fb};
      s2_sign <= s1_sign;
      s2_nv <= s1_nv;
      s2_inf <= s1_inf;
      s2_zero <= s1_zero;
      s2_man <= man_n;
      s2_g <= g_n;
      s2_r <= r_n;
      s2_s <= st_n;
      s2_e <= e_n;
      result <= res_n;
      flags <= flg_n;
    end
  end
endmodule

// File: tb/tb_float_mult_pipe.sv
// tb_float_mult_pipe: vector table, stall/reset sequences and random stream vs an arithmetic reference model
module tb_float_mult_pipe;
  logic clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0] flags;
  int checks = 0;
  int failures = 0;
  int rcv = 0;
  logic [63:0] pend[$];
  logic [35:0] expq[$];
  logic hold_chk = 1'b0;
  logic [31:0] hold_res;
  logic [3:0] hold_flg;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0] flg;
  } vec_t;
  vec_t tbl[$];

  float_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: exact integer product, rounded by comparing the discarded remainder to half an ulp
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
    logic s, nx, ny, ix, iy, zx, zy;
    int ex, ey, e, sh;
    longint unsigned p, q, rem, half;
    s = x[31] ^ y[31];
    ex = {24'h0, x[30:23]};
    ey = {24'h0, y[30:23]};
    zx = ex == 0;
    zy = ey == 0;
    ix = ex == 255 && x[22:0] == 0;
    iy = ey == 255 && y[22:0] == 0;
    nx = ex == 255 && x[22:0] != 0;
    ny = ey == 255 && y[22:0] != 0;
    if (nx || ny || (ix && zy) || (zx && iy)) return {4'b1000, 32'h7FC00000};
    if (ix || iy) return {4'b0000, s, 8'hFF, 23'h0};
    if (zx || zy) return {4'b0000, s, 31'h0};
    p = {40'h0, 1'b1, x[22:0]} * {40'h0, 1'b1, y[22:0]};
    e = ex + ey - 127;
    sh = 23;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e = e + 1;
    end
    q = p >> sh;
    rem = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {4'b0101, s, 8'hFF, 23'h0};
    if (e <= 0) return {4'b0011, s, 31'h0};
    return {3'b000, rem != 0, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    int r;
    logic [7:0] e;
    logic [22:0] f;
    r = $urandom_range(0, 9);
    f = 23'($urandom);
    if (r == 0) e = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
    else if (r < 7) e = 8'($urandom_range(100, 154));
    else e = 8'($urandom);
    if (r == 9) f = f | 23'h7FFF00;
    if (r == 0 && $urandom_range(0, 1) == 1) f = '0;
    return {1'($urandom), e, f};
  endfunction

  // One cycle of streaming: drive at negedge, score transfers that the next posedge will perform
  task automatic step(input logic ordy);
    logic [35:0] e;
    @(negedge clk);
    out_ready = ordy;
    in_valid = pend.size() > 0;
    if (in_valid) {a, b} = pend[0];
    #1;
    if (hold_chk) begin
      check("hold_res", 64'(result), 64'(hold_res));
      check("hold_flg", 64'(flags), 64'(hold_flg));
    end
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL stream_extra: got result %0h with no expected entry", result);
      end else begin
        e = expq.pop_front();
        check("stream_res", 64'(result), 64'(e[31:0]));
        check("stream_flg", 64'(flags), 64'(e[35:32]));
        rcv++;
      end
    end
    if (in_valid && in_ready) begin
      expq.push_back(model(a, b));
      void'(pend.pop_front());
    end
    hold_chk = out_valid && !out_ready;
    hold_res = result;
    hold_flg = flags;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    tbl.push_back('{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000});
    tbl.push_back('{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001});
    tbl.push_back('{32'h3F800001, 32'h3F7FFFFF, 32'h3F800000, 4'b0001});
    tbl.push_back('{32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101});
    tbl.push_back('{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011});
    tbl.push_back('{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000});
    tbl.push_back('{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000});
    tbl.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000});
    tbl.push_back('{32'h80000000, 32'h40000000, 32'h80000000, 4'b0000});
    tbl.push_back('{32'hBFC00000, 32'h40000000, 32'hC0400000, 4'b0000});
    tbl.push_back('{32'h7F800000, 32'hFF800000, 32'hFF800000, 4'b0000});
    tbl.push_back('{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000});
    tbl.push_back('{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001});
    tbl.push_back('{32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 4'b0001});
    tbl.push_back('{32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000});
    tbl.push_back('{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 4'b0000});
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    foreach (tbl[i]) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = tbl[i].a;
      b = tbl[i].b;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 8) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("vec%0d_latency", i), 64'(n), 64'd3);
      check($sformatf("vec%0d_res", i), 64'(result), 64'(tbl[i].res));
      check($sformatf("vec%0d_flg", i), 64'(flags), 64'(tbl[i].flg));
    end
    // back-to-back stream with out_ready low in cycles 4..8
    hold_chk = 1'b0;
    rcv = 0;
    for (int i = 0; i < 8; i++) pend.push_back({rnd_op(), rnd_op()});
    for (int c = 1; c <= 30; c++) begin
      step(!(c >= 4 && c <= 8));
      if (c == 3) check("b2b_ready_c3", 64'(in_ready), 64'd1);
      if (c == 4) begin
        check("b2b_ready_c4", 64'(in_ready), 64'd0);
        check("b2b_valid_c4", 64'(out_valid), 64'd1);
      end
    end
    check("b2b_count", 64'(rcv), 64'd8);
    // random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      if (pend.size() == 0 && $urandom_range(0, 3) != 0) pend.push_back({rnd_op(), rnd_op()});
      step($urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 40 && (expq.size() > 0 || pend.size() > 0); i++) step(1'b1);
    check("rand_drain", 64'(expq.size() + pend.size()), 64'd0);
    // reset with three operations in flight
    for (int i = 0; i < 3; i++) pend.push_back({rnd_op(), rnd_op()});
    for (int i = 0; i < 3; i++) step(1'b1);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("midrst_quiet", 64'(out_valid), 64'd0);
    end
    expq.delete();
    pend.delete();
    hold_chk = 1'b0;
    rcv = 0;
    pend.push_back({32'h3FC00000, 32'h40000000});
    for (int i = 0; i < 10; i++) step(1'b1);
    check("postrst_count", 64'(rcv), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
